// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter_if
//  Purpose  : Bundles the functional-unit result handshake and the
//             register-file write ports of the writeback arbiter.
//  Signals  : flush_i                 - synchronous flush request
//             fu_valid_i/waddr/wdata  - per-FU result offer
//             fu_ready_o              - per-FU result accepted (if valid)
//             we_o/waddr_o/wdata_o    - register-file write ports
//             busy_o                  - any result buffered
//  Modports : master - functional-unit / pipeline side (drives results)
//             slave  - writeback arbiter side
//  Revision : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if #(
    parameter int NR_FU          = 4,
    parameter int NR_WRITE_PORTS = 2,
    parameter int DATA_WIDTH     = 64
);
    logic                                  flush_i;
    logic [NR_FU-1:0]                      fu_valid_i;
    logic [NR_FU-1:0][4:0]                 fu_waddr_i;
    logic [NR_FU-1:0][DATA_WIDTH-1:0]      fu_wdata_i;
    logic [NR_FU-1:0]                      fu_ready_o;
    logic [NR_WRITE_PORTS-1:0]             we_o;
    logic [NR_WRITE_PORTS-1:0][4:0]        waddr_o;
    logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_o;
    logic                                  busy_o;

    modport master (
        output flush_i, fu_valid_i, fu_waddr_i, fu_wdata_i,
        input  fu_ready_o, we_o, waddr_o, wdata_o, busy_o
    );

    modport slave (
        input  flush_i, fu_valid_i, fu_waddr_i, fu_wdata_i,
        output fu_ready_o, we_o, waddr_o, wdata_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Writeback stage in front of the integer register file. Buffers
//             one result per functional unit and drains the buffers through
//             up to NR_WRITE_PORTS register-file write ports per cycle using
//             round-robin arbitration with same-address conflict skipping.
//  Ports    : clk_i   - clock
//             rst_ni  - asynchronous active-low reset
//             bus     - wb_arbiter_if.slave (results in, write ports out)
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int NR_FU          = 4,
    parameter int NR_WRITE_PORTS = 2,
    parameter int DATA_WIDTH     = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    wb_arbiter_if.slave   bus
);

    localparam int RR_W = (NR_FU > 1) ? $clog2(NR_FU) : 1;

    // Per-FU single-entry result buffers
    logic [NR_FU-1:0]                  hold_valid_q, hold_valid_d;
    logic [NR_FU-1:0][4:0]             hold_addr_q,  hold_addr_d;
    logic [NR_FU-1:0][DATA_WIDTH-1:0]  hold_data_q,  hold_data_d;
    logic [RR_W-1:0]                   rr_q,         rr_d;

    // Arbitration results
    logic [NR_FU-1:0]                          grant;
    logic [NR_FU-1:0]                          ready;
    logic [NR_FU-1:0]                          accept;
    logic [NR_WRITE_PORTS-1:0]                 we;
    logic [NR_WRITE_PORTS-1:0][4:0]            waddr;
    logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata;
    logic [RR_W-1:0]                           last_gnt;
    logic                                      any_gnt;
    logic                                      conflict;
    int                                        n_gnt;
    int                                        scan_idx;

    // ------------------------------------------------------------------------
    // Grant: walk the FUs starting at rr_q. Only buffered state feeds this
    // scan, so the write ports never depend on the current fu_* inputs.
    // A buffer whose destination matches an address already granted this
    // cycle is skipped and stays buffered for a later cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        grant    = '0;
        we       = '0;
        waddr    = '0;
        wdata    = '0;
        last_gnt = rr_q;
        any_gnt  = 1'b0;
        conflict = 1'b0;
        n_gnt    = 0;
        scan_idx = 0;
        if (!bus.flush_i) begin
            for (int s = 0; s < NR_FU; s++) begin
                scan_idx = int'(rr_q) + s;
                if (scan_idx >= NR_FU) begin
                    scan_idx = scan_idx - NR_FU;
                end
                for (int i = 0; i < NR_FU; i++) begin
                    if ((i == scan_idx) && hold_valid_q[i] && (n_gnt < NR_WRITE_PORTS)) begin
                        conflict = 1'b0;
                        for (int k = 0; k < NR_WRITE_PORTS; k++) begin
                            if ((k < n_gnt) && (waddr[k] == hold_addr_q[i])) begin
                                conflict = 1'b1;
                            end
                        end
                        if (!conflict) begin
                            grant[i] = 1'b1;
                            // The n-th grant in scan order owns write port n
                            for (int k = 0; k < NR_WRITE_PORTS; k++) begin
                                if (k == n_gnt) begin
                                    we[k]    = 1'b1;
                                    waddr[k] = hold_addr_q[i];
                                    wdata[k] = hold_data_q[i];
                                end
                            end
                            n_gnt    = n_gnt + 1;
                            last_gnt = RR_W'(i);
                            any_gnt  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Ready / capture / pointer next-state. A buffer is free when empty or
    // being drained this cycle, which gives one result per cycle per FU.
    // Results targeting x0 complete the handshake but are dropped.
    // ------------------------------------------------------------------------
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        ready        = '0;
        accept       = '0;
        for (int i = 0; i < NR_FU; i++) begin
            ready[i]  = ~bus.flush_i & (~hold_valid_q[i] | grant[i]);
            accept[i] = bus.fu_valid_i[i] & ready[i] & (bus.fu_waddr_i[i] != 5'd0);
            if (bus.flush_i) begin
                hold_valid_d[i] = 1'b0;
            end else if (accept[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_addr_d[i]  = bus.fu_waddr_i[i];
                hold_data_d[i]  = bus.fu_wdata_i[i];
            end else if (grant[i]) begin
                hold_valid_d[i] = 1'b0;
            end
        end

        rr_d = rr_q;
        if (any_gnt) begin
            if (int'(last_gnt) >= NR_FU - 1) begin
                rr_d = '0;
            end else begin
                rr_d = last_gnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_valid_q <= '0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            rr_q         <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            rr_q         <= rr_d;
        end
    end

    assign bus.fu_ready_o = ready;
    assign bus.we_o       = we;
    assign bus.waddr_o    = waddr;
    assign bus.wdata_o    = wdata;
    assign bus.busy_o     = |hold_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter
//  Purpose  : Directed self-checking bench for wb_arbiter. Expected register
//             writes are queued as results are offered and popped as the
//             write ports fire; handshake/status outputs are checked inline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int NR_FU = 4;
    localparam int NWP   = 2;
    localparam int DW    = 64;

    typedef struct packed {
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    wr_t           exp_q[$];
    logic [DW-1:0] rf [0:31];
    int            n_assert = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.NR_FU(NR_FU), .NR_WRITE_PORTS(NWP), .DATA_WIDTH(DW)) bus ();

    wb_arbiter #(.NR_FU(NR_FU), .NR_WRITE_PORTS(NWP), .DATA_WIDTH(DW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pop one expected write per asserted port, in port order.
    task automatic check_writes(input string tag);
        for (int k = 0; k < NWP; k++) begin
            if (bus.we_o[k] === 1'b1) begin
                wr_t e;
                n_assert++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL %s_unexpected_write: port %0d observed addr %0d expected no write",
                           tag, k, bus.waddr_o[k]);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk({tag, "_addr"}, DW'(bus.waddr_o[k]), DW'(e.addr));
                    chk({tag, "_data"}, bus.wdata_o[k], e.data);
                    rf[bus.waddr_o[k]] = bus.wdata_o[k];
                end
            end
        end
    endtask

    task automatic idle_inputs();
        bus.flush_i    = 1'b0;
        bus.fu_valid_i = '0;
        bus.fu_waddr_i = '0;
        bus.fu_wdata_i = '0;
    endtask

    task automatic offer(input int fu, input logic [4:0] addr, input logic [DW-1:0] data, input bit expect_write);
        bus.fu_valid_i[fu] = 1'b1;
        bus.fu_waddr_i[fu] = addr;
        bus.fu_wdata_i[fu] = data;
        if (expect_write) exp_q.push_back('{addr: addr, data: data});
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        exp_q.delete();
        cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: reset values, then idle after release
        chk("rst_ready", DW'(bus.fu_ready_o), DW'(4'b1111));
        chk("rst_we",    DW'(bus.we_o), '0);
        chk("rst_busy",  DW'(bus.busy_o), '0);
        chk("rst_waddr", DW'(bus.waddr_o), '0);
        chk("rst_wdata0", bus.wdata_o[0], '0);
        chk("rst_wdata1", bus.wdata_o[1], '0);
        rst_n = 1'b1;
        cycle();
        chk("idle_ready", DW'(bus.fu_ready_o), DW'(4'b1111));
        chk("idle_we",    DW'(bus.we_o), '0);
        chk("idle_busy",  DW'(bus.busy_o), '0);

        // 2: single result, one-cycle latency
        offer(0, 5'd5, 64'hDEAD, 1'b1);
        chk("t2_readyN", DW'(bus.fu_ready_o[0]), 1);
        cycle();
        chk("t2_we",     DW'(bus.we_o), DW'(2'b01));
        chk("t2_busy",   DW'(bus.busy_o), 1);
        chk("t2_ready0", DW'(bus.fu_ready_o[0]), 1);
        check_writes("t2");
        idle_inputs();
        cycle();
        chk("t2_busy_clr", DW'(bus.busy_o), 0);
        chk("t2_we_clr",   DW'(bus.we_o), '0);
        check_writes("t2_idle");

        // 2b: back-to-back throughput on one FU
        offer(0, 5'd6, 64'hA0, 1'b1);
        for (int j = 1; j <= 3; j++) begin
            cycle();
            chk("b2b_we",    DW'(bus.we_o), DW'(2'b01));
            chk("b2b_ready", DW'(bus.fu_ready_o), DW'(4'b1111));
            check_writes("b2b");
            if (j < 3) offer(0, 5'd6, 64'hA0 + DW'(j), 1'b1);
            else       idle_inputs();
        end
        cycle();
        chk("b2b_busy_clr", DW'(bus.busy_o), 0);

        // 3: four FUs at once, two ports
        do_reset();
        for (int f = 0; f < NR_FU; f++) offer(f, 5'(f + 1), 64'h100 + DW'(f), 1'b1);
        cycle();
        idle_inputs();
        chk("t3_we1",    DW'(bus.we_o), DW'(2'b11));
        chk("t3_ready1", DW'(bus.fu_ready_o), DW'(4'b0011));
        check_writes("t3_c1");
        cycle();
        chk("t3_we2",    DW'(bus.we_o), DW'(2'b11));
        chk("t3_ready2", DW'(bus.fu_ready_o), DW'(4'b1111));
        check_writes("t3_c2");
        cycle();
        chk("t3_we3",    DW'(bus.we_o), '0);
        chk("t3_busy3",  DW'(bus.busy_o), 0);

        // 4: same destination from two FUs is serialised in rr order
        do_reset();
        offer(1, 5'd7, 64'h11, 1'b1);
        offer(2, 5'd7, 64'h22, 1'b1);
        cycle();
        idle_inputs();
        chk("t4_we1",    DW'(bus.we_o), DW'(2'b01));
        chk("t4_ready1", DW'(bus.fu_ready_o), DW'(4'b1011));
        check_writes("t4_c1");
        cycle();
        chk("t4_we2",    DW'(bus.we_o), DW'(2'b01));
        check_writes("t4_c2");
        cycle();
        chk("t4_we3",    DW'(bus.we_o), '0);
        chk("t4_busy3",  DW'(bus.busy_o), 0);
        chk("t4_x7_final", rf[7], 64'h22);

        // 5: x0 destination is accepted and dropped
        offer(3, 5'd0, 64'h55, 1'b0);
        chk("t5_ready3", DW'(bus.fu_ready_o[3]), 1);
        cycle();
        idle_inputs();
        chk("t5_busy", DW'(bus.busy_o), 0);
        chk("t5_we",   DW'(bus.we_o), '0);
        check_writes("t5_c1");
        cycle();
        chk("t5_we2",  DW'(bus.we_o), '0);

        // 6a: flush with three entries buffered
        offer(0, 5'd8,  64'h8,  1'b0);
        offer(1, 5'd9,  64'h9,  1'b0);
        offer(2, 5'd10, 64'hA,  1'b0);
        @(posedge clk);
        #1;
        idle_inputs();
        chk("t6_busy_pre", DW'(bus.busy_o), 1);
        bus.flush_i = 1'b1;
        #1;
        chk("t6_flush_we",    DW'(bus.we_o), '0);
        chk("t6_flush_ready", DW'(bus.fu_ready_o), '0);
        cycle();
        bus.flush_i = 1'b0;
        #1;
        chk("t6_post_busy",  DW'(bus.busy_o), 0);
        chk("t6_post_we",    DW'(bus.we_o), '0);
        chk("t6_post_ready", DW'(bus.fu_ready_o), DW'(4'b1111));
        check_writes("t6_post");

        // 6b: asynchronous reset mid-cycle with entries buffered
        offer(0, 5'd11, 64'hB, 1'b0);
        offer(1, 5'd12, 64'hC, 1'b0);
        offer(2, 5'd13, 64'hD, 1'b0);
        @(posedge clk);
        #1;
        idle_inputs();
        chk("t6r_busy_pre", DW'(bus.busy_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6r_we",    DW'(bus.we_o), '0);
        chk("t6r_busy",  DW'(bus.busy_o), 0);
        chk("t6r_ready", DW'(bus.fu_ready_o), DW'(4'b1111));
        chk("t6r_waddr", DW'(bus.waddr_o), '0);
        chk("t6r_wdata0", bus.wdata_o[0], '0);
        #2 rst_n = 1'b1;
        cycle();
        chk("t6r_post_busy", DW'(bus.busy_o), 0);
        chk("t6r_post_we",   DW'(bus.we_o), '0);
        check_writes("t6r_post");

        chk("scoreboard_drained", DW'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
